// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// Register-to-memory store engine. On an accepted start it captures a DATA_W
// register value and a base byte address, then writes the value to data memory
// as little-endian BUS_W-wide beats over a req/ack bus. Completion is reported
// with a one-cycle done pulse; a beat that is not acknowledged within TIMEOUT
// cycles aborts the store with a one-cycle err pulse.
//
// Parameters
//   DATA_W   width of the stored register value
//   BUS_W    memory data-bus width; BEATS = ceil(DATA_W / BUS_W)
//   ADDR_W   byte-address width (addresses wrap modulo 2**ADDR_W)
//   TIMEOUT  cycles to wait for mem_ack on one beat (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      store request, honoured only while idle
//   R          register value, sampled on the accepted start
//   addr       base byte address, sampled on the accepted start
//   busy       high whenever a store is in progress (state != IDLE)
//   done       one-cycle pulse after the last beat is acknowledged
//   err        one-cycle pulse when a beat times out
//   mem_req    beat valid
//   mem_we     write enable, always equal to mem_req
//   mem_addr   byte address of the current beat
//   mem_wdata  byte of the current beat
//   mem_ack    memory accepted the current beat (ignored when mem_req = 0)
//
// Every output is decoded from registers only, so there is no combinational
// path from mem_ack or start to any output.
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int DATA_W  = 20,
  parameter int BUS_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] R,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic              mem_ack
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int BEATS  = (DATA_W + BUS_W - 1) / BUS_W;
  localparam int PAD_W  = BEATS * BUS_W;   // captured value, zero-padded
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  // Elaboration-time guards against parameter sets the datapath cannot serve.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("store_unit: TIMEOUT must be >= 1");
  end
  if (BUS_W < 1 || DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
    $error("store_unit: DATA_W, BUS_W and ADDR_W must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PAD_W-1:0]    data_q,  data_d;   // captured R, zero-extended
  logic [ADDR_W-1:0]   base_q,  base_d;   // captured base address
  logic [BEAT_W-1:0]   beat_q,  beat_d;   // index of the beat on the bus
  logic [TMO_W-1:0]    tmo_q,   tmo_d;    // unacknowledged cycles on this beat

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge value of every other register, independent of process order.
  // NOTE: the captured data/address registers are reset as well; they feed the
  // bus outputs and must never expose X, and there are only a few dozen flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a hold/default value first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    base_d  = base_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = PAD_W'(R);
          base_d  = addr;
          beat_d  = '0;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // An ack in the expiry cycle is still honoured: ack is tested first.
        if (mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            tmo_d  = '0;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registers only)
  // ---------------------------------------------------------------------------
  logic [BUS_W-1:0] beat_byte;

  always_comb begin
    beat_byte = data_q[int'(beat_q) * BUS_W +: BUS_W];
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);
  assign mem_req = (state_q == S_REQ);
  assign mem_we  = mem_req;

  // The bus is driven to zero outside REQ so a released bus is quiet and the
  // reset values of mem_addr/mem_wdata fall out directly.
  assign mem_addr  = mem_req ? (base_q + ADDR_W'(beat_q)) : '0;
  assign mem_wdata = mem_req ? beat_byte : '0;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Self-checking bench for store_unit (instantiated with TIMEOUT = 4).
//  - A responder plays memory: per beat of the current store it waits a
//    configured number of cycles before acking (-1 = never ack).
//  - A transaction-level model tracks "which beat is on the bus and how long it
//    has waited" and derives the expected bus contents arithmetically from the
//    captured value and base address; one compare process checks it against
//    the DUT on every falling edge.
//  - Directed tests additionally pin cycle counts and accepted beats to
//    hand-computed literals.
// -----------------------------------------------------------------------------
module tb_store_unit;

  localparam int DATA_W = 20;
  localparam int BUS_W  = 8;
  localparam int ADDR_W = 16;
  localparam int TMO    = 4;
  localparam int BEATS  = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] R     = '0;
  logic [ADDR_W-1:0] addr  = '0;
  logic              busy, done, err, mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [BUS_W-1:0]  mem_wdata;

  store_unit #(
    .DATA_W (DATA_W),
    .BUS_W  (BUS_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .R        (R),
    .addr     (addr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder
  // ---------------------------------------------------------------------------
  int wcfg [BEATS];
  int r_bi, r_wc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bi <= 0;
      r_wc <= 0;
    end else if (mem_req && mem_ack) begin
      r_bi <= r_bi + 1;
      r_wc <= 0;
    end else if (mem_req) begin
      r_wc <= r_wc + 1;
    end else if (!busy) begin
      r_bi <= 0;
      r_wc <= 0;
    end
  end

  assign mem_ack = mem_req && (r_bi < BEATS) && (wcfg[r_bi] >= 0) && (r_wc >= wcfg[r_bi]);

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  logic              m_active = 1'b0;
  logic              m_done   = 1'b0;
  logic              m_err    = 1'b0;
  int                m_k      = 0;     // beat on the bus
  int                m_wait   = 0;     // unacked cycles spent on it so far
  logic [DATA_W-1:0] m_val    = '0;
  logic [ADDR_W-1:0] m_base   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_k      <= 0;
      m_wait   <= 0;
    end else if (m_done || m_err) begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
    end else if (m_active) begin
      if (mem_ack) begin
        if (m_k == BEATS - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_k    <= m_k + 1;
          m_wait <= 0;
        end
      end else if (m_wait + 1 == TMO) begin
        m_active <= 1'b0;
        m_err    <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_wait   <= 0;
      m_val    <= R;
      m_base   <= addr;
    end
  end

  // Accepted beats, {addr, data}, for the literal checks.
  logic [23:0] beat_log [$];

  always @(negedge clk) begin
    check("busy",    32'(busy),    32'(m_active | m_done | m_err));
    check("done",    32'(done),    32'(m_done));
    check("err",     32'(err),     32'(m_err));
    check("mem_req", 32'(mem_req), 32'(m_active));
    check("mem_we",  32'(mem_we),  32'(m_active));
    if (m_active) begin
      check("mem_addr",  32'(mem_addr),  (int'(m_base) + m_k) % 65536);
      check("mem_wdata", 32'(mem_wdata), (int'(m_val) >> (8 * m_k)) & 255);
    end
    if (mem_req && mem_ack) beat_log.push_back({mem_addr, mem_wdata});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Cycle numbering: start is accepted at edge 0; cycle n follows edge n-1.
  task automatic run_store(input logic [DATA_W-1:0] r, input logic [ADDR_W-1:0] a,
                           input int w0, input int w1, input int w2, input int busy_start,
                           output int done_cyc, output int err_cyc,
                           output int busy_cyc, output int req_cyc);
    bit ended = 0;
    wcfg[0] = w0; wcfg[1] = w1; wcfg[2] = w2;
    beat_log.delete();
    done_cyc = -1; err_cyc = -1; busy_cyc = 0; req_cyc = 0;
    @(posedge clk); #2;
    start = 1'b1; R = r; addr = a;
    @(posedge clk); #2;
    R = ~r; addr = ~a;   // later changes must not affect the store
    for (int c = 1; c <= 40; c++) begin
      if (c == busy_start) begin
        start = 1'b1; R = 20'hABCDE; addr = 16'h0200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy)    busy_cyc++;
      if (mem_req) req_cyc++;
      if (done)    done_cyc = c;
      if (err)     err_cyc  = c;
      if (!busy && (done_cyc > 0 || err_cyc > 0)) begin
        ended = 1;
        break;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
    if (!ended) check("store_completes", 32'd0, 32'd1);
  endtask

  task automatic check_beats(input string name, input int n,
                             input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2);
    logic [23:0] exp [3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    check({name, "_count"}, beat_log.size(), n);
    for (int i = 0; i < n && i < beat_log.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 32'(beat_log[i]), 32'(exp[i]));
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int dc, ec, bc, rc;
    int cnt;

    wcfg[0] = 0; wcfg[1] = 0; wcfg[2] = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",  32'(busy),      0);
    check("rst_done",  32'(done),      0);
    check("rst_err",   32'(err),       0);
    check("rst_req",   32'(mem_req),   0);
    check("rst_we",    32'(mem_we),    0);
    check("rst_addr",  32'(mem_addr),  0);
    check("rst_wdata", 32'(mem_wdata), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic store, zero-wait memory
    run_store(20'h12345, 16'h0100, 0, 0, 0, 0, dc, ec, bc, rc);
    check("basic_done_cyc", dc, 4);
    check("basic_err_cyc",  ec, -1);
    check("basic_busy_cyc", bc, 4);
    check_beats("basic", 3, 24'h0100_45, 24'h0101_23, 24'h0102_01);

    // Two wait cycles on beat 1 only
    run_store(20'h12345, 16'h0100, 0, 2, 0, 0, dc, ec, bc, rc);
    check("wait_done_cyc", dc, 6);
    check("wait_err_cyc",  ec, -1);
    check("wait_req_cyc",  rc, 5);
    check_beats("wait", 3, 24'h0100_45, 24'h0101_23, 24'h0102_01);

    // Address wrap
    run_store(20'hFFFFF, 16'hFFFF, 0, 0, 0, 0, dc, ec, bc, rc);
    check("wrap_done_cyc", dc, 4);
    check_beats("wrap", 3, 24'hFFFF_FF, 24'h0000_FF, 24'h0001_0F);

    // Timeout: beat 1 never acked, presented for TMO cycles
    run_store(20'h12345, 16'h0100, 0, -1, 0, 0, dc, ec, bc, rc);
    check("tmo_err_cyc",  ec, 6);
    check("tmo_done_cyc", dc, -1);
    check("tmo_req_cyc",  rc, 5);
    check_beats("tmo", 1, 24'h0100_45, 24'h0, 24'h0);
    run_store(20'h12345, 16'h0100, 0, 0, 0, 0, dc, ec, bc, rc);
    check("post_tmo_done_cyc", dc, 4);

    // Ack in the expiry cycle wins
    run_store(20'h54321, 16'h0300, 0, TMO - 1, 0, 0, dc, ec, bc, rc);
    check("expiry_done_cyc", dc, 7);
    check("expiry_err_cyc",  ec, -1);
    check_beats("expiry", 3, 24'h0300_21, 24'h0301_43, 24'h0302_05);

    // Start while busy is ignored
    run_store(20'h12345, 16'h0100, 0, 0, 0, 2, dc, ec, bc, rc);
    check("busy_start_done_cyc", dc, 4);
    check_beats("busy_start", 3, 24'h0100_45, 24'h0101_23, 24'h0102_01);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("busy_start_no_second", cnt, 0);

    // Reset mid-transfer during beat 1
    wcfg[0] = 0; wcfg[1] = -1; wcfg[2] = 0;
    @(posedge clk); #2;
    start = 1'b1; R = 20'h12345; addr = 16'h0100;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);              // cycle 1: beat 0
    @(negedge clk);              // cycle 2: beat 1 waiting
    check("pre_rst_req", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),      0);
    check("mid_rst_req",   32'(mem_req),   0);
    check("mid_rst_we",    32'(mem_we),    0);
    check("mid_rst_addr",  32'(mem_addr),  0);
    check("mid_rst_wdata", 32'(mem_wdata), 0);
    check("mid_rst_done",  32'(done),      0);
    check("mid_rst_err",   32'(err),       0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || err || busy) cnt++;
    end
    check("post_rst_quiet", cnt, 0);
    run_store(20'h00001, 16'h0010, 0, 0, 0, 0, dc, ec, bc, rc);
    check("post_rst_done_cyc", dc, 4);
    check_beats("post_rst", 3, 24'h0010_01, 24'h0011_00, 24'h0012_00);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
